// File: rtl/cpu_axi_pkg.sv
// Shared types and fixed AXI4 field encodings for the CPU-side AXI master port.
// Every transfer is a single-beat INCR burst of one full data word.
package cpu_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_ADDR,
        S_WR_RESP,
        S_DONE
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

endpackage

// File: rtl/cpu_axi_master.sv
// Converts the core's single-cycle memory requests into single-beat AXI4 reads/writes
// and stalls the core until the transfer completes.
module cpu_axi_master
    import cpu_axi_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              ID_W     = 4,
    parameter logic [ID_W-1:0] ID_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    // core side
    input  logic              req_read,
    input  logic              req_write,
    input  logic [3:0]        req_web,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              hold,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              resp_err,
    // read address channel
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    // read data channel
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    // write address channel
    output logic [ID_W-1:0]   AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [7:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,
    // write data channel
    output logic [DATA_W-1:0] WDATA,
    output logic [3:0]        WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    // write response channel
    input  logic [ID_W-1:0]   BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
);

    state_e            state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done, w_done;
    logic              aw_ok, w_ok;

    // Response IDs are not compared; only one transaction is ever outstanding.
    logic unused_ids;
    assign unused_ids = ^{RID, BID};

    assign stall = (req_read | req_write) & (state != S_DONE);

    // Fixed burst fields; payloads come only from the captured request registers.
    assign ARID    = ID_VALUE;
    assign ARADDR  = addr_q;
    assign ARLEN   = LEN_SINGLE;
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;
    assign AWID    = ID_VALUE;
    assign AWADDR  = addr_q;
    assign AWLEN   = LEN_SINGLE;
    assign AWSIZE  = SIZE_WORD;
    assign AWBURST = BURST_INCR;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;

    // A channel counts as finished if it completed earlier or handshakes this cycle.
    assign aw_ok = aw_done | AWREADY;
    assign w_ok  = w_done  | WREADY;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rdata    <= '0;
            resp_err <= 1'b0;
        end else begin
            state    <= state_next;
            resp_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (req_read | req_write) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= ~req_web;
                    end
                end
                S_RD_DATA: begin
                    if (RVALID && RLAST) begin
                        rdata    <= RDATA;
                        resp_err <= (RRESP != RESP_OKAY);
                    end
                end
                S_WR_ADDR: begin
                    if (AWVALID && AWREADY) aw_done <= 1'b1;
                    if (WVALID && WREADY)   w_done  <= 1'b1;
                end
                S_WR_RESP: begin
                    if (BVALID) resp_err <= (BRESP != RESP_OKAY);
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        AWVALID    = 1'b0;
        WVALID     = 1'b0;
        BREADY     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_read)       state_next = S_RD_ADDR;
                else if (req_write) state_next = S_WR_ADDR;
            end
            S_RD_ADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                RREADY = 1'b1;
                if (RVALID && RLAST) state_next = S_DONE;
            end
            S_WR_ADDR: begin
                AWVALID = ~aw_done;
                WVALID  = ~w_done;
                if (aw_ok && w_ok) state_next = S_WR_RESP;
            end
            S_WR_RESP: begin
                BREADY = 1'b1;
                if (BVALID) state_next = S_DONE;
            end
            S_DONE: begin
                if (!hold) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_axi_master.sv
// Directed bench for cpu_axi_master: the AXI slave side is driven by hand, cycle by cycle,
// and every observed value is compared against a hand-computed constant.
module tb_cpu_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read, req_write, hold;
    logic [3:0]  req_web;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_err;
    logic [31:0] rdata;
    logic [3:0]  ARID, AWID, RID, BID;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
    logic [7:0]  ARLEN, AWLEN;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [3:0]  WSTRB;

    int errors = 0;
    int checks = 0;
    int ar_hs  = 0;
    int aw_seen = 0;
    int ar_base, aw_base;

    always #5 clk = ~clk;

    cpu_axi_master dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write), .req_web(req_web),
        .req_addr(req_addr), .req_wdata(req_wdata), .hold(hold),
        .stall(stall), .rdata(rdata), .resp_err(resp_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always @(posedge clk) begin
        if (ARVALID && ARREADY) ar_hs++;
        if (AWVALID) aw_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_read = 0; req_write = 0; hold = 0; req_web = 4'hF;
        req_addr = 0; req_wdata = 0;
        ARREADY = 0; AWREADY = 0; WREADY = 0;
        RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
        BID = 0; BRESP = 0; BVALID = 0;
        #3;
        check("rst_stall",   stall,   0);
        check("rst_arvalid", ARVALID, 0);
        check("rst_awvalid", AWVALID, 0);
        check("rst_wvalid",  WVALID,  0);
        check("rst_rready",  RREADY,  0);
        check("rst_bready",  BREADY,  0);
        check("rst_rdata",   rdata,   0);
        check("rst_resp_err", resp_err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1. basic read, 3-cycle latency
        tick();
        req_read = 1; req_addr = 32'h10; ARREADY = 1;
        #1 check("rd_stall_same_cycle", stall, 1);
        check("rd_idle_arvalid", ARVALID, 0);
        tick(); #1;
        check("rd_arvalid", ARVALID, 1);
        check("rd_araddr",  ARADDR,  32'h10);
        check("rd_arlen",   ARLEN,   0);
        check("rd_arsize",  ARSIZE,  3'b010);
        check("rd_arburst", ARBURST, 2'b01);
        check("rd_arid",    ARID,    0);
        check("rd_stall_c1", stall,  1);
        tick();
        RVALID = 1; RDATA = 32'hDEADBEEF; RLAST = 1; RRESP = 0;
        #1 check("rd_rready", RREADY, 1);
        check("rd_arvalid_low", ARVALID, 0);
        check("rd_stall_c2", stall, 1);
        tick();
        RVALID = 0; RLAST = 0; ARREADY = 0;
        #1 check("rd_done_stall", stall, 0);
        check("rd_rdata", rdata, 32'hDEADBEEF);
        check("rd_rready_low", RREADY, 0);
        check("rd_resp_err_ok", resp_err, 0);
        tick();
        #1 check("rd_stall_back_idle", stall, 1);
        req_read = 0;

        // 2. write, AW accepted one cycle before W
        tick();
        req_write = 1; req_web = 4'b1100; req_wdata = 32'h12345678; req_addr = 32'h20;
        AWREADY = 1; WREADY = 0;
        #1 check("wr_stall_same_cycle", stall, 1);
        tick(); #1;
        check("wr_awvalid", AWVALID, 1);
        check("wr_wvalid",  WVALID,  1);
        check("wr_awaddr",  AWADDR,  32'h20);
        check("wr_wdata",   WDATA,   32'h12345678);
        check("wr_wstrb",   WSTRB,   4'b0011);
        check("wr_wlast",   WLAST,   1);
        check("wr_awlen",   AWLEN,   0);
        check("wr_awsize",  AWSIZE,  3'b010);
        check("wr_awburst", AWBURST, 2'b01);
        tick();
        AWREADY = 0; WREADY = 1;
        #1 check("wr_awvalid_dropped", AWVALID, 0);
        check("wr_wvalid_still", WVALID, 1);
        check("wr_stall_mid", stall, 1);
        tick();
        WREADY = 0; BVALID = 1; BRESP = 0;
        #1 check("wr_wvalid_dropped", WVALID, 0);
        check("wr_bready", BREADY, 1);
        check("wr_stall_resp", stall, 1);
        tick();
        BVALID = 0; req_write = 0; req_web = 4'hF;
        #1 check("wr_done_stall", stall, 0);
        check("wr_bready_low", BREADY, 0);
        check("wr_resp_err_ok", resp_err, 0);
        check("wr_rdata_held", rdata, 32'hDEADBEEF);

        // 3. ARREADY backpressure for 5 cycles
        tick();
        ar_base = ar_hs;
        req_read = 1; req_addr = 32'h44; ARREADY = 0;
        tick();
        req_addr = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("bp_arvalid_%0d", i), ARVALID, 1);
            check($sformatf("bp_araddr_%0d", i), ARADDR, 32'h44);
            tick();
        end
        ARREADY = 1;
        tick();
        ARREADY = 0; RVALID = 1; RLAST = 1; RDATA = 32'hCAFEF00D;
        #1 check("bp_arvalid_low", ARVALID, 0);
        tick();
        RVALID = 0; RLAST = 0; req_read = 0;
        #1 check("bp_rdata", rdata, 32'hCAFEF00D);
        check("bp_one_ar_handshake", ar_hs - ar_base, 1);

        // 4. hold keeps DONE
        tick();
        ar_base = ar_hs;
        req_read = 1; req_addr = 32'h80; ARREADY = 1; hold = 1;
        tick();
        tick();
        RVALID = 1; RLAST = 1; RDATA = 32'h0BADF00D;
        tick();
        RVALID = 0; RLAST = 0;
        #1 check("hold_done_stall", stall, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 check($sformatf("hold_stall_%0d", i), stall, 0);
            check($sformatf("hold_arvalid_%0d", i), ARVALID, 0);
            check($sformatf("hold_rdata_%0d", i), rdata, 32'h0BADF00D);
        end
        hold = 0;
        tick();
        req_read = 0;
        tick();
        req_read = 1;
        #1 check("hold_back_idle", stall, 1);
        req_read = 0;
        check("hold_one_ar_handshake", ar_hs - ar_base, 1);

        // 5a. error response on read
        tick();
        req_read = 1; req_addr = 32'h90; ARREADY = 1;
        tick();
        tick();
        RVALID = 1; RLAST = 1; RDATA = 32'h55AA55AA; RRESP = 2'b10;
        #1 check("err_no_early_pulse", resp_err, 0);
        tick();
        RVALID = 0; RLAST = 0; RRESP = 0; req_read = 0;
        #1 check("err_resp_err", resp_err, 1);
        check("err_stall", stall, 0);
        check("err_rdata", rdata, 32'h55AA55AA);
        tick();
        #1 check("err_pulse_one_cycle", resp_err, 0);

        // 5b. reset in WR_RESP
        req_write = 1; req_addr = 32'h30; req_web = 4'h0; AWREADY = 1; WREADY = 1;
        tick();
        tick();
        #1 check("rstw_bready", BREADY, 1);
        rst = 1; req_write = 0;
        #1 check("rstw_bready_low", BREADY, 0);
        check("rstw_stall", stall, 0);
        check("rstw_awvalid", AWVALID, 0);
        check("rstw_rdata_cleared", rdata, 0);
        tick();
        rst = 0; AWREADY = 0; WREADY = 0; BVALID = 1; req_web = 4'hF;
        tick();
        #1 check("rstw_no_completion_bready", BREADY, 0);
        check("rstw_no_resp_err", resp_err, 0);
        BVALID = 0;

        // 6. simultaneous read+write: read wins
        tick();
        aw_base = aw_seen;
        req_read = 1; req_write = 1; req_addr = 32'hA0; ARREADY = 1; AWREADY = 1; WREADY = 1;
        tick();
        #1 check("sim_arvalid", ARVALID, 1);
        check("sim_awvalid", AWVALID, 0);
        check("sim_araddr", ARADDR, 32'hA0);
        tick();
        RVALID = 1; RLAST = 1; RDATA = 32'h600DCAFE;
        #1 check("sim_awvalid_rd", AWVALID, 0);
        tick();
        RVALID = 0; RLAST = 0; req_read = 0; req_write = 0;
        #1 check("sim_rdata", rdata, 32'h600DCAFE);
        check("sim_stall", stall, 0);
        tick();
        tick();
        #1 check("sim_awvalid_never", aw_seen - aw_base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
